// File: rtl/ram_b_access_ctrl.sv
// Load/store front end for a byte-enabled, word-addressed RAM port with 1-cycle read latency.
// Byte/half/word requests are mapped onto one or two word accesses; load data is merged and extended.
module ram_b_access_ctrl #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_we,
    input  logic [31:0]           ram_dout,
    output logic [2:0]            dbg_state
);

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is high whenever the FSM is IDLE. rsp_valid is a one-cycle pulse, no backpressure.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A0   = 3'd1,
        A1   = 3'd2,
        L0   = 3'd3,
        L1   = 3'd4
    } state_t;

    state_t                state_q;
    logic                  we_q;
    logic                  uns_q;
    logic                  split_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] w1_q;
    logic [3:0]            m1_q;
    logic [31:0]           d1_q;
    logic [31:0]           lo_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [31:0]           ram_din_q;
    logic [3:0]            ram_we_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_rdata_q;

    logic [3:0]            base_m;
    logic [7:0]            lane_m;
    logic [63:0]           wsh;
    logic [ADDR_WIDTH-1:0] w0;
    logic [ADDR_WIDTH-1:0] w1;

    assign w0 = req_addr[ADDR_WIDTH+1:2];
    assign w1 = w0 + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        base_m = 4'b1111;
        case (req_size)
            2'd0:    base_m = 4'b0001;
            2'd1:    base_m = 4'b0011;
            default: base_m = 4'b1111;
        endcase
        lane_m = {4'b0000, base_m} << req_addr[1:0];
        wsh    = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
    end

    // x holds {word1, word0}; shift the addressed byte down to bit 0, then extend.
    function automatic logic [31:0] fmt(input logic [63:0] x, input logic [1:0] o,
                                        input logic [1:0] sz, input logic uns);
        logic [63:0] y;
        logic [31:0] r;
        y = x >> {o, 3'b000};
        case (sz)
            2'd0:    r = uns ? {24'b0, y[7:0]}  : {{24{y[7]}},  y[7:0]};
            2'd1:    r = uns ? {16'b0, y[15:0]} : {{16{y[15]}}, y[15:0]};
            default: r = y[31:0];
        endcase
        return r;
    endfunction

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            w1_q        <= '0;
            m1_q        <= 4'b0;
            d1_q        <= 32'b0;
            lo_q        <= 32'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 32'b0;
            ram_we_q    <= 4'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        size_q  <= req_size;
                        split_q <= |lane_m[7:4];
                        w1_q    <= w1;
                        m1_q    <= lane_m[7:4];
                        d1_q    <= wsh[63:32];
                        if (req_size == 2'd3) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            ram_addr_q <= w0;
                            ram_we_q   <= req_we ? lane_m[3:0] : 4'b0;
                            ram_din_q  <= req_we ? wsh[31:0]   : 32'b0;
                            state_q    <= A0;
                        end
                    end
                end
                A0: begin
                    if (split_q) begin
                        ram_addr_q <= w1_q;
                        ram_we_q   <= we_q ? m1_q : 4'b0;
                        ram_din_q  <= we_q ? d1_q : 32'b0;
                        state_q    <= A1;
                    end else begin
                        ram_we_q  <= 4'b0;
                        ram_din_q <= 32'b0;
                        if (we_q) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= L0;
                        end
                    end
                end
                A1: begin
                    ram_we_q  <= 4'b0;
                    ram_din_q <= 32'b0;
                    if (we_q) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        lo_q    <= ram_dout;
                        state_q <= L1;
                    end
                end
                L0: begin
                    rsp_rdata_q <= fmt({32'b0, ram_dout}, off_q, size_q, uns_q);
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                L1: begin
                    rsp_rdata_q <= fmt({ram_dout, lo_q}, off_q, size_q, uns_q);
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_b_access_ctrl.sv
// Directed bench for ram_b_access_ctrl: a behavioural RAM, a driver, and a monitor that
// pops hand-computed response and RAM-write expectations from queues.
module tb_ram_b_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  ram_addr;
    logic [31:0] ram_din;
    logic [3:0]  ram_we;
    logic [31:0] ram_dout;
    logic [2:0]  dbg_state;

    ram_b_access_ctrl #(.ADDR_WIDTH(6)) dut (
        .clka(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] acc;
        logic [31:0] lat;
    } rsp_t;

    typedef struct packed {
        logic [5:0]  a;
        logic [3:0]  we;
        logic [31:0] d;
    } wr_t;

    rsp_t        exp_q[$];
    wr_t         wr_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] cyc    = 32'd0;
    logic [31:0] mem [64];
    bit          mem_ready = 1'b0;
    rsp_t        mon_r;
    wr_t         mon_w;

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Behavioural RAM, each word preloaded with its own index in every byte
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= {4{i[7:0]}};
            mem_ready <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor / scoreboard
    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_r = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_r.rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_r.err});
                check("rsp_latency", cyc - mon_r.acc + 32'd1, mon_r.lat);
            end
        end
        if (ram_we != 4'b0) begin
            if (wr_q.size() == 0) begin
                check("unexpected_ram_write", {28'b0, ram_we}, 32'd0);
            end else begin
                mon_w = wr_q.pop_front();
                check("ram_addr", {26'b0, ram_addr}, {26'b0, mon_w.a});
                check("ram_we", {28'b0, ram_we}, {28'b0, mon_w.we});
                check("ram_din", ram_din, mon_w.d);
            end
        end
    end

    task automatic exp_wr(input logic [5:0] a, input logic [3:0] we, input logic [31:0] d);
        wr_q.push_back('{a: a, we: we, d: d});
    endtask

    // Driver: presents a request, waits (bounded) for req_ready, queues the expected response
    task automatic issue(input logic we, input logic [7:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, output int waits, output logic rv_seen);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        waits        = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        rv_seen = rsp_valid;
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            exp_q.push_back('{rdata: exp_rdata, err: exp_err, acc: cyc + 32'd1, lat: lat});
            @(posedge clk);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", (k < 100) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int   w;
        logic rv;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 8'h00;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ram_we", {28'b0, ram_we}, 32'd0);
        check("rst_ram_addr", {26'b0, ram_addr}, 32'd0);
        check("rst_ram_din", ram_din, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        rst_n = 1'b1;

        // Aligned word and byte lanes
        exp_wr(6'd4, 4'b1111, 32'h11223344);
        issue(1'b1, 8'h10, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0, 2, w, rv);
        issue(1'b0, 8'h10, 2'd2, 1'b0, 32'h0, 32'h11223344, 1'b0, 3, w, rv);
        exp_wr(6'd4, 4'b1000, 32'hA5000000);
        issue(1'b1, 8'h13, 2'd0, 1'b0, 32'h000000A5, 32'h0, 1'b0, 2, w, rv);
        issue(1'b0, 8'h13, 2'd0, 1'b0, 32'h0, 32'hFFFFFFA5, 1'b0, 3, w, rv);
        issue(1'b0, 8'h13, 2'd0, 1'b1, 32'h0, 32'h000000A5, 1'b0, 3, w, rv);

        // Split half across words 1/2
        exp_wr(6'd1, 4'b1000, 32'hEF000000);
        exp_wr(6'd2, 4'b0001, 32'h000000BE);
        issue(1'b1, 8'h07, 2'd1, 1'b0, 32'h0000BEEF, 32'h0, 1'b0, 3, w, rv);
        issue(1'b0, 8'h07, 2'd1, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0, 4, w, rv);
        issue(1'b0, 8'h07, 2'd1, 1'b1, 32'h0, 32'h0000BEEF, 1'b0, 4, w, rv);

        // Split word wrapping from word 63 to word 0; neighbours untouched
        exp_wr(6'd63, 4'b1100, 32'hBEEF0000);
        exp_wr(6'd0, 4'b0011, 32'h0000DEAD);
        issue(1'b1, 8'hFE, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 3, w, rv);
        issue(1'b0, 8'hFE, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 4, w, rv);
        issue(1'b0, 8'hF8, 2'd2, 1'b0, 32'h0, 32'h3E3E3E3E, 1'b0, 3, w, rv);
        issue(1'b0, 8'h04, 2'd2, 1'b0, 32'h0, 32'hEF010101, 1'b0, 3, w, rv);

        // Illegal size, then a legal request accepted in the error-response cycle
        issue(1'b1, 8'h08, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, w, rv);
        issue(1'b0, 8'h00, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1, w, rv);
        issue(1'b0, 8'h00, 2'd1, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0, 3, w, rv);
        check("b2b_after_err_wait", w, 32'd0);
        check("b2b_after_err_rsp", {31'b0, rv}, 32'd1);

        // Request held through a split load: accepted on the response cycle
        issue(1'b0, 8'h11, 2'd2, 1'b0, 32'h0, 32'h05A52233, 1'b0, 4, w, rv);
        issue(1'b0, 8'h12, 2'd0, 1'b0, 32'h0, 32'h00000022, 1'b0, 3, w, rv);
        check("busy_wait_cycles", w, 32'd3);
        check("busy_accept_on_rsp", {31'b0, rv}, 32'd1);
        wait_drain();

        // Reset during A1 of a split store: first word committed, second dropped, no response
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 8'h23;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        req_wdata    = 32'h00001234;
        exp_wr(6'd8, 4'b1000, 32'h34000000);
        exp_wr(6'd9, 4'b0001, 32'h00000012);
        check("rst_test_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_test_in_a1", {29'b0, dbg_state}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ram_we", {28'b0, ram_we}, 32'd0);
        check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {31'b0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        check("rst_writes_seen", wr_q.size(), 32'd0);
        issue(1'b0, 8'h23, 2'd0, 1'b1, 32'h0, 32'h00000034, 1'b0, 3, w, rv);
        issue(1'b0, 8'h24, 2'd0, 1'b1, 32'h0, 32'h00000009, 1'b0, 3, w, rv);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_b_access_ctrl.md
Name: ram_b_access_ctrl

Overview:
- Initiator-side controller for the byte-enabled, word-addressed, 1-cycle-read-latency data RAM port (addr/din/we[3:0]/dout).
- Converts byte-addressed byte/half/word load/store requests from the core's load-store stage into RAM word accesses.
- Misaligned accesses are split into two word accesses; returned data is merged and sign- or zero-extended.
- Sits between the core data bus and the RAM instance; one outstanding request at a time.

Parameters:
- ADDR_WIDTH, 6, RAM word-address width. Byte address is ADDR_WIDTH+2 bits; RAM depth is 2^ADDR_WIDTH words.

Ports:
- clka  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH+2  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data, right-justified (low n bytes used)
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  32  load result (0 for stores and errors)
- rsp_err  out  1  qualifies rsp_valid; 1 = illegal size
- ram_addr  out  ADDR_WIDTH  RAM word address (registered)
- ram_din  out  32  RAM write data (registered)
- ram_we  out  4  RAM byte write enables, bit0 = byte 0 (registered)
- ram_dout  in  32  RAM read data, valid in the cycle after the RAM samples ram_addr

Behaviour:
- Reset (async, rst_n low): state = IDLE; ram_addr, ram_din, rsp_rdata = 0; ram_we = 0; rsp_valid = 0; rsp_err = 0; req_valid ignored.
- req_ready = 1 exactly when state == IDLE, including the cycle rsp_valid is high. Back-to-back requests are therefore allowed.
- Address arithmetic:
  - o = req_addr[1:0]; n = 1/2/4 bytes; w0 = req_addr[ADDR_WIDTH+1:2]; w1 = (w0 + 1) mod 2^ADDR_WIDTH, wrapping from the top word to word 0.
  - split = (o + n > 4).
  - 8-bit lane mask M = ((1 << n) - 1) << o; m0 = M[3:0], m1 = M[7:4].
  - S = {32'b0, req_wdata} << 8*o (64 bits); d0 = S[31:0], d1 = S[63:32].
- FSM states: IDLE, A0, A1, L0, L1. Request fields are latched on accept.
- IDLE, on accept with size != 3: ram_addr <= w0; ram_we <= store ? m0 : 0; ram_din <= store ? d0 : 0; go to A0.
- IDLE, on accept with size == 3: no RAM access. Next edge: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; stay in IDLE.
- A0 (RAM samples word 0 at the end of this cycle):
  - If split: ram_addr <= w1; ram_we <= store ? m1 : 0; ram_din <= store ? d1 : 0; go to A1.
  - Else: ram_we <= 0, ram_din <= 0. Store: rsp_valid <= 1, go to IDLE. Load: go to L0.
- A1: ram_we <= 0; ram_din <= 0.
  - Load: capture lo <= ram_dout (word 0 data), go to L1.
  - Store: rsp_valid <= 1, go to IDLE.
- L0: rsp_rdata <= fmt({32'b0, ram_dout}); rsp_valid <= 1; go to IDLE.
- L1: rsp_rdata <= fmt({ram_dout, lo}); rsp_valid <= 1; go to IDLE.
- fmt(x): y = x >> 8*o; keep the low n bytes; extend from bit 8n-1 with sign (req_unsigned = 0) or zeros.
- Response timing, counted from accept edge E:
  - aligned store: E+2
  - aligned load: E+3
  - split store: E+3
  - split load: E+4
  - illegal size: E+1
- rsp_valid is high for exactly one cycle. rsp_err = 0 and rsp_rdata = 0 on store responses.
- ram_we is nonzero only in A0/A1 cycles and never for loads.
- Reset mid-operation: outputs return to reset values immediately and the pending request is dropped with no response. A write whose edge already occurred stays committed.

Test Plan:
- Aligned word: store 0x11223344 @0x10 → A0 shows ram_addr = 4, ram_we = 1111, ram_din = 0x11223344; rsp at E+2. Load word @0x10 → rsp_rdata = 0x11223344 at E+3.
- Byte store 0xA5 @0x13 → ram_we = 1000, ram_din = 0xA5000000. Signed byte load @0x13 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Split half: store 0xBEEF @0x07:
  - word 1: ram_we = 1000, ram_din = 0xEF000000
  - word 2: ram_we = 0001, ram_din = 0x000000BE; rsp at E+3
  - signed half load @0x07 → 0xFFFFBEEF at E+4.
- Wrap: word store 0xDEADBEEF @0xFE (ADDR_WIDTH = 6):
  - word 63: ram_we = 1100, ram_din = 0xBEEF0000
  - word 0: ram_we = 0011, ram_din = 0x0000DEAD
  - load back → 0xDEADBEEF; words 62 and 1 unchanged.
- Illegal size 3 → ram_we stays 0; rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 at E+1. Next legal request accepted in the same cycle; its response has rsp_err = 0.
- Busy and reset:
  - req_valid held during a split load → req_ready = 0 until IDLE; second request accepted on the rsp_valid cycle.
  - rst_n pulsed low in A1 of a split store → ram_we = 0 immediately, no rsp_valid, req_ready = 1 after release.
